// File: rtl/rst_pkg.sv
// Shared encodings for the reset sequencer: reset-cause codes, FSM states and
// a small elaboration-time helper.
package rst_pkg;

  typedef enum logic [1:0] {
    CAUSE_POWER  = 2'b00,
    CAUSE_BUTTON = 2'b01,
    CAUSE_SW     = 2'b10
  } cause_e;

  typedef enum logic [1:0] {
    S_HOLD,
    S_RELEASE,
    S_RUN
  } state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/rst_debounce.sv
// Push-button conditioner: 2-flop synchroniser, stability counter, debounced
// level and a one-cycle pulse on each debounced press (1->0).
module rst_debounce #(
  parameter int DEBOUNCE_CYCLES = 65536
) (
  input  logic clock,
  input  logic rst_n,
  input  logic raw_n,
  output logic level_n,
  output logic fall_pulse
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);

  logic [1:0]       sync_q;
  logic             level_q;
  logic             fall_q;
  logic [CNT_W-1:0] cnt_q;

  // NOTE: sequential state is only ever written with <=, so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= 2'b11;
      level_q <= 1'b1;
      fall_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync_q <= {sync_q[0], raw_n};
      fall_q <= 1'b0;
      if (sync_q[1] == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        level_q <= sync_q[1];
        fall_q  <= level_q;  // a change away from a high level is a press
        cnt_q   <= '0;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign level_n    = level_q;
  assign fall_pulse = fall_q;

endmodule

// File: rtl/reset_sequencer.sv
// Merges power, button and software resets into one ordered release sequence
// across NUM_STAGES domains and records the cause of the last reset.
module reset_sequencer
  import rst_pkg::*;
#(
  parameter int NUM_STAGES      = 3,
  parameter int HOLD_CYCLES     = 1024,
  parameter int STAGE_GAP       = 16,
  parameter int DEBOUNCE_CYCLES = 65536
) (
  input  logic                  clock,
  input  logic                  rst_n,
  input  logic                  btn_n,
  input  logic                  sw_rst_req,
  output logic [NUM_STAGES-1:0] rst_stage_n,
  output logic                  busy,
  output logic [1:0]            rst_cause
);

  localparam int CNT_W = $clog2(max_int(HOLD_CYCLES, STAGE_GAP)) + 1;
  localparam int IDX_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

  logic [1:0]            rst_sync_q;
  logic                  rst_int_n;
  logic                  level_n;
  logic                  press_evt;
  logic                  trig;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [NUM_STAGES-1:0] stage_q, stage_d;
  logic                  busy_q, busy_d;
  cause_e                cause_q, cause_d;

  // NOTE: asynchronous assert, synchronous deassert; the synchronised reset
  // then clears every other flop so nothing leaves reset on a metastable edge.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) rst_sync_q <= 2'b00;
    else        rst_sync_q <= {rst_sync_q[0], 1'b1};
  end

  assign rst_int_n = rst_sync_q[1];

  rst_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clock     (clock),
    .rst_n     (rst_int_n),
    .raw_n     (btn_n),
    .level_n   (level_n),
    .fall_pulse(press_evt)
  );

  assign trig = press_evt | sw_rst_req;

  always_ff @(posedge clock or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state_q <= S_HOLD;
      cnt_q   <= '0;
      idx_q   <= '0;
      stage_q <= '0;
      busy_q  <= 1'b1;
      cause_q <= CAUSE_POWER;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      stage_q <= stage_d;
      busy_q  <= busy_d;
      cause_q <= cause_d;
    end
  end

  // NOTE: every next-state signal takes its current value first, so no path
  // through the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    stage_d = stage_q;
    busy_d  = busy_q;
    cause_d = cause_q;

    if (trig) cause_d = press_evt ? CAUSE_BUTTON : CAUSE_SW;

    unique case (state_q)
      S_HOLD: begin
        // A held button keeps restarting the hold window.
        if (trig || !level_n) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_W'(HOLD_CYCLES - 1)) begin
          stage_d[0] = 1'b1;
          idx_d      = IDX_W'(1);
          cnt_d      = '0;
          state_d    = (NUM_STAGES > 1) ? S_RELEASE : S_RUN;
          busy_d     = (NUM_STAGES > 1);
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_RELEASE: begin
        if (cnt_q == CNT_W'(STAGE_GAP - 1)) begin
          stage_d[idx_q] = 1'b1;
          idx_d          = idx_q + IDX_W'(1);
          cnt_d          = '0;
          if (idx_q == IDX_W'(NUM_STAGES - 1)) begin
            state_d = S_RUN;
            busy_d  = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_RUN: ;
      default: state_d = S_HOLD;
    endcase

    if (trig && state_q != S_HOLD) begin
      state_d = S_HOLD;
      stage_d = '0;
      busy_d  = 1'b1;
      cnt_d   = '0;
      idx_d   = '0;
    end
  end

  assign rst_stage_n = stage_q;
  assign busy        = busy_q;
  assign rst_cause   = cause_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Self-checking bench for reset_sequencer: an edge-counting reference model
// compared every cycle, directed scenarios with literal timings, then random traffic.
module tb_reset_sequencer;

  localparam int N = 3;
  localparam int H = 8;
  localparam int G = 4;
  localparam int D = 5;

  logic         clock = 1'b0;
  logic         rst_n;
  logic         btn_n;
  logic         sw_rst_req;
  logic [N-1:0] rst_stage_n;
  logic         busy;
  logic [1:0]   rst_cause;

  int n_checks = 0;
  int n_errs   = 0;
  bit cmp_en   = 1'b0;

  reset_sequencer #(
    .NUM_STAGES     (N),
    .HOLD_CYCLES    (H),
    .STAGE_GAP      (G),
    .DEBOUNCE_CYCLES(D)
  ) dut (
    .clock      (clock),
    .rst_n      (rst_n),
    .btn_n      (btn_n),
    .sw_rst_req (sw_rst_req),
    .rst_stage_n(rst_stage_n),
    .busy       (busy),
    .rst_cause  (rst_cause)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: counts edges; stage k is released once the edge count
  // reaches anchor + H + k*G, where anchor is the latest edge that restarted
  // the sequence (T0, a trigger, or a held button during the hold window).
  int         cyc     = 0;
  int         anchor  = 0;
  logic       m_rs1   = 1'b0;
  logic       m_rs2   = 1'b0;
  logic       m_b1    = 1'b1;
  logic       m_b2    = 1'b1;
  logic       m_level = 1'b1;
  logic       m_press = 1'b0;
  int         m_run   = 0;
  logic [1:0] m_cause = 2'b00;

  always @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      m_rs1 = 1'b0; m_rs2 = 1'b0;
      m_b1 = 1'b1; m_b2 = 1'b1; m_level = 1'b1; m_press = 1'b0; m_run = 0;
      m_cause = 2'b00;
    end else begin
      cyc = cyc + 1;
      if (m_rs2) begin
        if (m_press || sw_rst_req) begin
          m_cause = m_press ? 2'b01 : 2'b10;
          anchor  = cyc;
        end else if (cyc <= anchor + H && !m_level) begin
          anchor = cyc;
        end
        m_press = 1'b0;
        if (m_b2 != m_level) begin
          m_run = m_run + 1;
          if (m_run == D) begin
            m_press = m_level;
            m_level = m_b2;
            m_run   = 0;
          end
        end else begin
          m_run = 0;
        end
        m_b2 = m_b1;
        m_b1 = btn_n;
      end else if (m_rs1) begin
        anchor = cyc;
      end
      m_rs2 = m_rs1;
      m_rs1 = 1'b1;
    end
  end

  function automatic logic [N-1:0] exp_stage();
    logic [N-1:0] v = '0;
    if (m_rs2)
      for (int k = 0; k < N; k++) v[k] = (cyc >= anchor + H + k * G);
    return v;
  endfunction

  always @(negedge clock) begin
    if (cmp_en) begin
      check("model_stage", 32'(rst_stage_n), 32'(exp_stage()));
      check("model_busy", 32'(busy), 32'(exp_stage() != {N{1'b1}}));
      check("model_cause", 32'(rst_cause), 32'(m_cause));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #2;
  endtask

  task automatic expect_out(input string name, input logic [N-1:0] st, input logic b,
                            input logic [1:0] c);
    check({name, "_stage"}, 32'(rst_stage_n), 32'(st));
    check({name, "_busy"}, 32'(busy), 32'(b));
    check({name, "_cause"}, 32'(rst_cause), 32'(c));
  endtask

  task automatic wait_stage(input logic [N-1:0] val, input int budget);
    bit found = 1'b0;
    for (int i = 0; i < budget && !found; i++) begin
      tick(1);
      found = (rst_stage_n == val);
    end
    check("wait_stage_timeout", 32'(found), 32'(1));
  endtask

  task automatic sw_pulse();
    sw_rst_req = 1'b1;
    tick(1);
    sw_rst_req = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; btn_n = 1'b1; sw_rst_req = 1'b0;
    @(posedge clock);
    cmp_en = 1'b1;
    #2;
    expect_out("reset_low", 3'b000, 1'b1, 2'b00);

    // Power-up
    tick(2);
    rst_n = 1'b1;
    tick(2);
    expect_out("pwr_t0", 3'b000, 1'b1, 2'b00);
    tick(7);
    expect_out("pwr_t0p7", 3'b000, 1'b1, 2'b00);
    tick(1);
    expect_out("pwr_t0p8", 3'b001, 1'b1, 2'b00);
    tick(3);
    expect_out("pwr_t0p11", 3'b001, 1'b1, 2'b00);
    tick(1);
    expect_out("pwr_t0p12", 3'b011, 1'b1, 2'b00);
    tick(4);
    expect_out("pwr_t0p16", 3'b111, 1'b0, 2'b00);

    // Software reset from RUN
    tick(3);
    sw_pulse();
    expect_out("sw_edge", 3'b000, 1'b1, 2'b10);
    tick(7);
    expect_out("sw_p7", 3'b000, 1'b1, 2'b10);
    tick(1);
    expect_out("sw_p8", 3'b001, 1'b1, 2'b10);
    tick(4);
    expect_out("sw_p12", 3'b011, 1'b1, 2'b10);
    tick(4);
    expect_out("sw_p16", 3'b111, 1'b0, 2'b10);

    // Bouncing button: no reset
    for (int i = 0; i < 5; i++) begin
      btn_n = 1'b0; tick(2);
      btn_n = 1'b1; tick(2);
    end
    tick(10);
    expect_out("bounce", 3'b111, 1'b0, 2'b10);

    // Held button: press seen after sync + debounce, hold extended until release
    btn_n = 1'b0;
    tick(7);
    expect_out("btn_pre", 3'b111, 1'b0, 2'b10);
    tick(1);
    expect_out("btn_edge", 3'b000, 1'b1, 2'b01);
    tick(22);
    btn_n = 1'b1;
    tick(14);
    expect_out("btn_held", 3'b000, 1'b1, 2'b01);
    tick(1);
    expect_out("btn_rel0", 3'b001, 1'b1, 2'b01);
    tick(8);
    expect_out("btn_done", 3'b111, 1'b0, 2'b01);

    // Simultaneous press and software request
    tick(2);
    sw_pulse();
    expect_out("sim_pre", 3'b000, 1'b1, 2'b10);
    wait_stage(3'b111, 100);
    btn_n = 1'b0;
    tick(7);
    sw_rst_req = 1'b1;
    tick(1);
    sw_rst_req = 1'b0;
    btn_n = 1'b1;
    expect_out("simul", 3'b000, 1'b1, 2'b01);

    // Re-trigger during RELEASE
    wait_stage(3'b001, 100);
    sw_pulse();
    expect_out("retrig", 3'b000, 1'b1, 2'b10);
    tick(7);
    expect_out("retrig_p7", 3'b000, 1'b1, 2'b10);
    tick(1);
    expect_out("retrig_p8", 3'b001, 1'b1, 2'b10);

    // Asynchronous rst_n pulse during RELEASE
    wait_stage(3'b011, 100);
    #1 rst_n = 1'b0;
    #1;
    expect_out("async_rst", 3'b000, 1'b1, 2'b00);
    tick(1);
    rst_n = 1'b1;
    tick(2);
    expect_out("rst_t0", 3'b000, 1'b1, 2'b00);
    tick(8);
    expect_out("rst_t0p8", 3'b001, 1'b1, 2'b00);

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) btn_n = ~btn_n;
      sw_rst_req = ($urandom_range(0, 59) == 0);
      if (!rst_n) rst_n = 1'b1;
      else if ($urandom_range(0, 499) == 0) rst_n = 1'b0;
      tick(1);
    end
    sw_rst_req = 1'b0;
    rst_n = 1'b1;
    btn_n = 1'b1;
    tick(40);
    expect_out("final_idle", 3'b111, 1'b0, m_cause);

    cmp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
